// File: rtl/layer_serializer.sv
// Parallel layer vector to serial word stream; LAYER_SERIALIZER_DOUBLE_BUF_EN adds a pending vector buffer.
// Latency: word 0 is presented 1 cycle after capture; back-to-back vectors stream with no bubble.
// Backpressure: out_ready stalls the word stream; in_busy flags inputs that would be dropped (overrun).
module layer_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int NEURONS    = 30,
  parameter int IDX_WIDTH  = $clog2(NEURONS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [NEURONS*DATA_WIDTH-1:0] in_data,
  output logic                          in_busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [IDX_WIDTH-1:0]          out_index,
  output logic                          out_last,
  output logic                          overrun
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                        state;
  logic [NEURONS*DATA_WIDTH-1:0] active_buf;
  logic [NEURONS*DATA_WIDTH-1:0] load_vec;
  logic                          beat;
  logic                          last_beat;
  logic                          load_en;
  logic                          pend_free;
  logic [IDX_WIDTH-1:0]          next_idx;
  logic [DATA_WIDTH-1:0]         next_word;

`ifdef LAYER_SERIALIZER_DOUBLE_BUF_EN
  logic [NEURONS*DATA_WIDTH-1:0] pend_buf;
  logic                          pend_vld;
  logic                          pend_take;
  logic                          pend_store;
  assign pend_free = ~pend_vld;
`else
  assign pend_free = 1'b0;
`endif

  assign beat      = out_valid & out_ready;
  assign last_beat = beat & out_last;
  // The last beat frees the active buffer in the same cycle, so an input there is never dropped.
  assign in_busy   = (state == SEND) & ~last_beat & ~pend_free;
  assign next_idx  = out_index + IDX_WIDTH'(1);
  assign next_word = active_buf[int'(next_idx)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    load_en  = 1'b0;
    load_vec = in_data;
`ifdef LAYER_SERIALIZER_DOUBLE_BUF_EN
    pend_take  = 1'b0;
    pend_store = 1'b0;
`endif
    if (state == IDLE) begin
      load_en = in_valid;
    end else if (last_beat) begin
      load_en = in_valid;
    end
`ifdef LAYER_SERIALIZER_DOUBLE_BUF_EN
    // A held vector always goes ahead of a newly arriving one, which then takes its slot.
    if (state == SEND) begin
      if (last_beat && pend_vld) begin
        load_en    = 1'b1;
        load_vec   = pend_buf;
        pend_take  = 1'b1;
        pend_store = in_valid;
      end else if (!last_beat) begin
        pend_store = in_valid & ~pend_vld;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      active_buf <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      out_last   <= 1'b0;
      overrun    <= 1'b0;
`ifdef LAYER_SERIALIZER_DOUBLE_BUF_EN
      pend_buf   <= '0;
      pend_vld   <= 1'b0;
`endif
    end else begin
      overrun <= in_valid & in_busy;
      if (load_en) begin
        state      <= SEND;
        active_buf <= load_vec;
        out_valid  <= 1'b1;
        out_data   <= load_vec[DATA_WIDTH-1:0];
        out_index  <= '0;
        out_last   <= 1'b0;
      end else if (last_beat) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else if (beat) begin
        out_index <= next_idx;
        out_data  <= next_word;
        out_last  <= (next_idx == IDX_WIDTH'(NEURONS - 1));
      end
`ifdef LAYER_SERIALIZER_DOUBLE_BUF_EN
      if (pend_store) begin
        pend_buf <= in_data;
        pend_vld <= 1'b1;
      end else if (pend_take) begin
        pend_vld <= 1'b0;
      end
`endif
    end
  end

endmodule
